// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle controller
package mc_pkg;

    typedef enum logic [2:0] {
        ST_VECTOR = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_ADDI = 3'd2,
        CLS_LW   = 3'd3,
        CLS_SW   = 3'd4,
        CLS_BEQ  = 3'd5,
        CLS_J    = 3'd6,
        CLS_ILL  = 3'd7
    } class_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_ENTRY  = 2'd3;

    // One bundle of every control output, so reset gating is a single mux.
    typedef struct packed {
        logic       mem_req;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       reg_dst;
        logic       alu_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem2reg;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode/funct to instruction class and ALU operation
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output class_e     cls,
    output logic [2:0] alu_op
);

    // Anything not explicitly recognised falls through to the illegal class.
    always_comb begin
        cls    = CLS_ILL;
        alu_op = ALU_AND;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_R;
                case (funct)
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: cls    = CLS_ILL;
                endcase
            end
            OP_ADDI: begin
                cls    = CLS_ADDI;
                alu_op = ALU_ADD;
            end
            OP_LW: begin
                cls    = CLS_LW;
                alu_op = ALU_ADD;
            end
            OP_SW: begin
                cls    = CLS_SW;
                alu_op = ALU_ADD;
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J: begin
                cls    = CLS_J;
            end
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle control FSM with memory timeout and vectoring
module mc_control
    import mc_pkg::*;
#(
    parameter int ENTRY_SEL_W = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   int_req,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   ir_we,
    output logic                   pc_we,
    output logic                   reg_we,
    output logic                   reg_dst,
    output logic                   alu_src,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic                   mem2reg,
    output logic                   branch,
    output logic                   jump,
    output logic [2:0]             alu_op,
    output logic [ENTRY_SEL_W-1:0] pc_src,
    output logic [2:0]             state,
    output logic                   illegal,
    output logic                   bus_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    class_e           cls_q, cls_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    class_e           dec_cls;
    logic [2:0]       dec_alu_op;
    ctrl_t            ctrl;
    ctrl_t            ctrl_gated;
    state_e           fetch_target;
    logic             timed_out;
    logic             alu_imm;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .alu_op (dec_alu_op)
    );

    // An interrupt is only taken at an instruction boundary, never mid-flight.
    assign fetch_target = int_req ? ST_VECTOR : ST_FETCH;
    // mem_ready on the limit cycle still wins because it is tested first.
    assign timed_out    = (cnt_q == CNT_LIMIT);
    assign alu_imm      = (cls_q == CLS_ADDI) || (cls_q == CLS_LW) || (cls_q == CLS_SW);

    // State, class/alu_op latch, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_VECTOR;
            cls_q     <= CLS_NONE;
            alu_op_q  <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state and Moore-style control outputs; the counter idles at zero
    // outside a waiting handshake, so every handshake entry starts cleared.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        alu_op_d  = alu_op_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ctrl      = '0;

        case (state_q)
            ST_VECTOR: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PC_SRC_ENTRY;
                state_d     = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = PC_SRC_SEQ;
                    state_d     = ST_DECODE;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_VECTOR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                cls_d    = dec_cls;
                alu_op_d = dec_alu_op;
                if (dec_cls == CLS_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = ST_VECTOR;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ctrl.alu_op  = alu_op_q;
                ctrl.alu_src = alu_imm;
                case (cls_q)
                    CLS_R, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:  state_d = ST_MEM;
                    CLS_BEQ: begin
                        ctrl.branch = 1'b1;
                        ctrl.pc_we  = zero;
                        ctrl.pc_src = PC_SRC_BRANCH;
                        state_d     = fetch_target;
                    end
                    CLS_J: begin
                        ctrl.jump   = 1'b1;
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_src = PC_SRC_JUMP;
                        state_d     = fetch_target;
                    end
                    default: state_d = ST_VECTOR;
                endcase
            end
            ST_MEM: begin
                ctrl.alu_op  = alu_op_q;
                ctrl.alu_src = alu_imm;
                ctrl.mem_req = 1'b1;
                ctrl.mem_rd  = (cls_q == CLS_LW);
                ctrl.mem_wr  = (cls_q == CLS_SW);
                if (mem_ready) begin
                    state_d = (cls_q == CLS_LW) ? ST_WB : fetch_target;
                end else if (timed_out) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_VECTOR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB: begin
                ctrl.alu_op  = alu_op_q;
                ctrl.alu_src = alu_imm;
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = (cls_q == CLS_R);
                ctrl.mem2reg = (cls_q == CLS_LW);
                state_d      = fetch_target;
            end
            default: state_d = ST_VECTOR;
        endcase
    end

    // Reset overrides every control output immediately, so a pending write
    // handshake is cut off in the same cycle rst_n drops.
    assign ctrl_gated = rst_n ? ctrl : '0;

    assign mem_req = ctrl_gated.mem_req;
    assign ir_we   = ctrl_gated.ir_we;
    assign pc_we   = ctrl_gated.pc_we;
    assign reg_we  = ctrl_gated.reg_we;
    assign reg_dst = ctrl_gated.reg_dst;
    assign alu_src = ctrl_gated.alu_src;
    assign mem_rd  = ctrl_gated.mem_rd;
    assign mem_wr  = ctrl_gated.mem_wr;
    assign mem2reg = ctrl_gated.mem2reg;
    assign branch  = ctrl_gated.branch;
    assign jump    = ctrl_gated.jump;
    assign alu_op  = ctrl_gated.alu_op;
    assign pc_src  = ENTRY_SEL_W'(ctrl_gated.pc_src);
    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - scoreboard bench for mc_control
module tb_mc_control;

    localparam logic [2:0] S_VEC = 3'd0;
    localparam logic [2:0] S_FET = 3'd1;
    localparam logic [2:0] S_DEC = 3'd2;
    localparam logic [2:0] S_EXE = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4;
    localparam logic [2:0] S_WB  = 3'd5;

    localparam logic [15:0] C_NONE   = 16'h0000;
    localparam logic [15:0] C_MREQ   = 16'h8000;
    localparam logic [15:0] C_IRWE   = 16'h4000;
    localparam logic [15:0] C_PCWE   = 16'h2000;
    localparam logic [15:0] C_REGWE  = 16'h1000;
    localparam logic [15:0] C_REGDST = 16'h0800;
    localparam logic [15:0] C_ALUSRC = 16'h0400;
    localparam logic [15:0] C_MRD    = 16'h0200;
    localparam logic [15:0] C_MWR    = 16'h0100;
    localparam logic [15:0] C_M2R    = 16'h0080;
    localparam logic [15:0] C_BR     = 16'h0040;
    localparam logic [15:0] C_JMP    = 16'h0020;
    localparam logic [15:0] C_FDONE  = 16'hE000;
    localparam logic [15:0] C_VECT   = 16'h2003;

    typedef struct {
        logic        rstn;
        logic        rdy;
        logic        irq;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [2:0]  st;
        logic [17:0] exp;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       int_req;
    logic       mem_ready;
    logic       mem_req, ir_we, pc_we, reg_we, reg_dst, alu_src;
    logic       mem_rd, mem_wr, mem2reg, branch, jump;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic       illegal;
    logic       bus_err;
    logic [15:0] obs;

    stim_t sb[$];
    int    checks = 0;
    int    errors = 0;

    logic       cur_rstn = 1'b1;
    logic       cur_irq  = 1'b0;
    logic       cur_z    = 1'b0;
    logic [5:0] cur_op   = 6'h00;
    logic [5:0] cur_fn   = 6'h00;
    logic       exp_ill  = 1'b0;
    logic       exp_berr = 1'b0;

    mc_control #(.ENTRY_SEL_W(2), .MEM_TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .int_req   (int_req),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .alu_src   (alu_src),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem2reg   (mem2reg),
        .branch    (branch),
        .jump      (jump),
        .alu_op    (alu_op),
        .pc_src    (pc_src),
        .state     (state),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    assign obs = {mem_req, ir_we, pc_we, reg_we, reg_dst, alu_src, mem_rd, mem_wr,
                  mem2reg, branch, jump, alu_op, pc_src};

    always #5 clk = ~clk;

    function automatic logic [15:0] aop(input logic [2:0] a);
        return {11'b0, a, 2'b0};
    endfunction

    function automatic logic [15:0] psrc(input logic [1:0] p);
        return {14'b0, p};
    endfunction

    task automatic push(input logic rdy, input logic [2:0] st, input logic [15:0] ctrl);
        stim_t s;
        s.rstn = cur_rstn;
        s.rdy  = rdy;
        s.irq  = cur_irq;
        s.z    = cur_z;
        s.op   = cur_op;
        s.fn   = cur_fn;
        s.st   = st;
        s.exp  = {exp_ill, exp_berr, ctrl};
        sb.push_back(s);
    endtask

    task automatic test_reset();
        stim_t s;
        int    n = 0;
        cur_rstn = 1'b0;
        push(1'b1, S_VEC, C_NONE);
        cur_rstn = 1'b1;
        push(1'b0, S_VEC, C_VECT);
        push(1'b0, S_FET, C_MREQ);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL reset c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_r_type();
        stim_t      s;
        int         n = 0;
        logic [5:0] fns [5];
        logic [2:0] ops [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        ops = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        cur_op = 6'h00;
        for (int i = 0; i < 5; i++) begin
            cur_fn = fns[i];
            push(1'b1, S_FET, C_FDONE);
            push(1'b1, S_DEC, C_NONE);
            push(1'b1, S_EXE, aop(ops[i]));
            push(1'b1, S_WB,  C_REGWE | C_REGDST | aop(ops[i]));
        end
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL r_type c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_store();
        stim_t s;
        int    n = 0;
        cur_op = 6'h23;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        for (int i = 0; i < 3; i++) push(1'b0, S_MEM, C_MREQ | C_MRD | C_ALUSRC | aop(3'b010));
        push(1'b1, S_MEM, C_MREQ | C_MRD | C_ALUSRC | aop(3'b010));
        push(1'b0, S_WB,  C_REGWE | C_M2R | C_ALUSRC | aop(3'b010));
        cur_op = 6'h2b;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        push(1'b1, S_MEM, C_MREQ | C_MWR | C_ALUSRC | aop(3'b010));
        cur_op = 6'h08;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        push(1'b0, S_WB,  C_REGWE | C_ALUSRC | aop(3'b010));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL load_store c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch_jump();
        stim_t s;
        int    n = 0;
        cur_op = 6'h04;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        cur_z = 1'b1;
        push(1'b0, S_EXE, C_BR | C_PCWE | psrc(2'd1) | aop(3'b110));
        cur_z = 1'b0;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_BR | psrc(2'd1) | aop(3'b110));
        cur_op = 6'h02;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_JMP | C_PCWE | psrc(2'd2));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL branch_jump c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_interrupt();
        stim_t s;
        int    n = 0;
        cur_op = 6'h08;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        cur_irq = 1'b1;
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        push(1'b0, S_WB,  C_REGWE | C_ALUSRC | aop(3'b010));
        cur_irq = 1'b0;
        push(1'b0, S_VEC, C_VECT);
        push(1'b0, S_FET, C_MREQ);
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        push(1'b0, S_WB,  C_REGWE | C_ALUSRC | aop(3'b010));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL interrupt c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        int    n = 0;
        cur_op = 6'h3f;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        exp_ill = 1'b1;
        push(1'b0, S_VEC, C_VECT);
        cur_op = 6'h00;
        cur_fn = 6'h3f;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_VEC, C_VECT);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL illegal c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        int    n = 0;
        for (int i = 0; i < 16; i++) push(1'b0, S_FET, C_MREQ);
        exp_berr = 1'b1;
        push(1'b0, S_VEC, C_VECT);
        cur_op = 6'h02;
        for (int i = 0; i < 15; i++) push(1'b0, S_FET, C_MREQ);
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_JMP | C_PCWE | psrc(2'd2));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL timeout c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_mem();
        stim_t s;
        int    n = 0;
        cur_op = 6'h2b;
        push(1'b1, S_FET, C_FDONE);
        push(1'b0, S_DEC, C_NONE);
        push(1'b0, S_EXE, C_ALUSRC | aop(3'b010));
        push(1'b0, S_MEM, C_MREQ | C_MWR | C_ALUSRC | aop(3'b010));
        cur_rstn = 1'b0;
        push(1'b1, S_MEM, C_NONE);
        exp_ill  = 1'b0;
        exp_berr = 1'b0;
        push(1'b1, S_VEC, C_NONE);
        cur_rstn = 1'b1;
        push(1'b0, S_VEC, C_VECT);
        push(1'b0, S_FET, C_MREQ);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            rst_n = s.rstn; mem_ready = s.rdy; int_req = s.irq; zero = s.z;
            opcode = s.op; funct = s.fn;
            #1;
            checks++;
            if ({state, illegal, bus_err, obs} !== {s.st, s.exp}) begin
                errors++;
                $display("FAIL reset_mid_mem c%0d: got st=%0d fl=%b ctrl=%h, want st=%0d fl=%b ctrl=%h",
                         n, state, {illegal, bus_err}, obs, s.st, s.exp[17:16], s.exp[15:0]);
            end
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        int_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_r_type();
        test_load_store();
        test_branch_jump();
        test_interrupt();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
